// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory.
package imem_loader_pkg;

    localparam int IMEM_DEPTH_WORDS = 512;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == ST_HDR) || (s == ST_DATA) || (s == ST_WRITE);
    endfunction

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and memory write port of the loader.
// slave = loader side, master = byte source / memory side.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four accepted bytes (first byte in [7:0]) into a 32-bit word.
// word/word_full are combinational so the 4th byte is usable in its own cycle.
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [23:0] shreg_r;
    logic [1:0]  cnt_r;

    assign word      = {byte_in, shreg_r};
    assign word_full = accept && (cnt_r == 2'd3);

    // Byte shift register and byte counter; partial words survive stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= 24'd0;
            cnt_r   <= 2'd0;
        end else if (clr) begin
            shreg_r <= 24'd0;
            cnt_r   <= 2'd0;
        end else if (accept) begin
            shreg_r <= {byte_in, shreg_r[23:8]};
            cnt_r   <= cnt_r + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian program image into instruction memory,
// holding the CPU in reset while the load is in progress.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = IMEM_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          CNT_W       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    imem_loader_if.slave     bus,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_written
);

    state_e             state_r;
    state_e             next_state_s;
    logic               start_ok_s;
    logic               accept_s;
    logic [31:0]        word_s;
    logic               word_full_s;
    logic [CNT_W-1:0]   n_r;
    logic [CNT_W-1:0]   words_written_r;
    logic               byte_ready_r;
    logic               wr_en_r;
    logic [31:0]        wr_addr_r;
    logic [31:0]        wr_data_r;
    logic               cpu_hold_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;

    assign accept_s      = byte_ready_r && bus.byte_valid;
    assign bus.byte_ready = byte_ready_r;
    assign bus.wr_en     = wr_en_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;
    assign cpu_hold      = cpu_hold_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;
    assign words_written = words_written_r;

    imem_loader_byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_ok_s),
        .accept    (accept_s),
        .byte_in   (bus.byte_data),
        .word      (word_s),
        .word_full (word_full_s)
    );

    // Next-state logic; abort beats start whenever a load is active.
    always_comb begin
        next_state_s = state_r;
        start_ok_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    next_state_s = ST_HDR;
                    start_ok_s   = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_HDR: begin
                if (abort) begin
                    next_state_s = ST_ERR;
                end else if (word_full_s) begin
                    if (word_s == 32'd0) begin
                        next_state_s = ST_DONE;
                    end else if (word_s > 32'(DEPTH_WORDS)) begin
                        next_state_s = ST_ERR;
                    end else begin
                        next_state_s = ST_DATA;
                    end
                end else begin
                    next_state_s = ST_HDR;
                end
            end
            ST_DATA: begin
                if (abort) begin
                    next_state_s = ST_ERR;
                end else if (word_full_s) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    next_state_s = ST_ERR;
                end else if ((words_written_r + CNT_W'(1)) == n_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, counters and write port; status flags decode the next state
    // so every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            n_r             <= '0;
            words_written_r <= '0;
            byte_ready_r    <= 1'b0;
            wr_en_r         <= 1'b0;
            wr_addr_r       <= 32'd0;
            wr_data_r       <= 32'd0;
            cpu_hold_r      <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            error_r         <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            byte_ready_r <= (next_state_s == ST_HDR) || (next_state_s == ST_DATA);
            busy_r       <= is_busy(next_state_s);
            cpu_hold_r   <= is_busy(next_state_s) || (next_state_s == ST_ERR);
            done_r       <= (next_state_s == ST_DONE);
            error_r      <= (next_state_s == ST_ERR);
            wr_en_r      <= (next_state_s == ST_WRITE);
            if (start_ok_s) begin
                n_r             <= '0;
                words_written_r <= '0;
            end else if (state_r == ST_WRITE) begin
                words_written_r <= words_written_r + CNT_W'(1);
            end
            if ((state_r == ST_HDR) && (next_state_s == ST_DATA)) begin
                n_r <= word_s[CNT_W-1:0];
            end
            if ((state_r == ST_DATA) && (next_state_s == ST_WRITE)) begin
                wr_addr_r <= word_addr(BASE_ADDR, 32'(words_written_r));
                wr_data_r <= word_s;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int CNT_W = 10;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             cpu_hold;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] words_written;

    int n_cmp = 0;
    int n_err = 0;
    int ready_viol = 0;
    int cyc = 0;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [31:0] exp_data[$];

    imem_loader_if bus();

    imem_loader #(.DEPTH_WORDS(512), .BASE_ADDR(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .bus           (bus),
        .cpu_hold      (cpu_hold),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wq_addr.push_back(bus.wr_addr);
            wq_data.push_back(bus.wr_data);
            if (bus.byte_ready !== 1'b0) ready_viol <= ready_viol + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        budget = 0;
        while (bus.byte_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) check("byte_ready_timeout", 32'(bus.byte_ready), 32'd1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], gaps ? int'($urandom_range(0, 1)) : 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int budget = 0;
        while (busy === 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) check(tag, 32'(busy), 32'd0);
    endtask

    task automatic clear_q();
        wq_addr.delete();
        wq_data.delete();
        exp_data.delete();
    endtask

    task automatic load_image(input bit gaps);
        pulse_start();
        send_word(32'(exp_data.size()), gaps);
        foreach (exp_data[i]) send_word(exp_data[i], gaps);
        wait_idle("load_timeout");
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_wcnt"}, 32'(wq_data.size()), 32'(exp_data.size()));
        foreach (exp_data[i]) begin
            check({tag, "_addr"}, (i < wq_addr.size()) ? wq_addr[i] : 32'hFFFF_FFFF, 32'(4 * i));
            check({tag, "_data"}, (i < wq_data.size()) ? wq_data[i] : ~exp_data[i], exp_data[i]);
        end
    endtask

    initial begin
        int c0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_flags", {26'd0, bus.byte_ready, bus.wr_en, cpu_hold, busy, done, error}, 32'd0);
        check("rst_ww", 32'(words_written), 32'd0);
        check("rst_addr", bus.wr_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three-word image
        clear_q();
        exp_data = '{32'h0000_0013, 32'h0010_0093, 32'hDEAD_BEEF};
        pulse_start();
        check("t1_busy", {30'd0, busy, cpu_hold}, 32'd3);
        send_word(32'd3, 1'b0);
        foreach (exp_data[i]) send_word(exp_data[i], 1'b0);
        wait_idle("t1_timeout");
        check_writes("t1");
        check("t1_flags", {28'd0, cpu_hold, busy, done, error}, 32'b0010);
        check("t1_ww", 32'(words_written), 32'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_ignored", {30'd0, done, error}, 32'b10);

        // Empty image
        clear_q();
        pulse_start();
        check("t2_ww_cleared", 32'(words_written), 32'd0);
        send_word(32'd0, 1'b0);
        check("t2_done", {29'd0, done, busy, cpu_hold}, 32'b100);
        check("t2_wcnt", 32'(wq_data.size()), 32'd0);

        // Oversized image
        clear_q();
        pulse_start();
        send_word(32'd513, 1'b0);
        check("t3_flags", {28'd0, cpu_hold, busy, done, error}, 32'b1001);
        bus.byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("t3_no_ready", 32'(bus.byte_ready), 32'd0);
        bus.byte_valid = 1'b0;
        check("t3_wcnt", 32'(wq_data.size()), 32'd0);

        // Eight words gap-free, then with random byte gaps
        clear_q();
        exp_data = '{32'h0000_0013, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000,
                     32'h8000_0001, 32'hA5A5_5A5A, 32'h0102_0304, 32'hCAFE_F00D};
        pulse_start();
        send_word(32'd8, 1'b0);
        c0 = cyc;
        foreach (exp_data[i]) send_word(exp_data[i], 1'b0);
        wait_idle("t4_timeout");
        check("t4_cycles", 32'(cyc - c0), 32'd40);
        check_writes("t4a");
        wq_addr.delete();
        wq_data.delete();
        load_image(1'b1);
        check_writes("t4b");
        check("t4_ready_in_write", 32'(ready_viol), 32'd0);

        // Abort after two of five words; start+abort together while busy
        clear_q();
        pulse_start();
        send_word(32'd5, 1'b0);
        send_word(32'h1111_1111, 1'b0);
        send_word(32'h2222_2222, 1'b0);
        send_byte(8'h33, 0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("t5_flags", {28'd0, cpu_hold, busy, done, error}, 32'b1001);
        check("t5_ww", 32'(words_written), 32'd2);
        check("t5_wcnt", 32'(wq_data.size()), 32'd2);
        clear_q();
        exp_data = '{32'hAAAA_0001, 32'hBBBB_0002};
        load_image(1'b0);
        check_writes("t5r");
        check("t5r_flags", {28'd0, cpu_hold, busy, done, error}, 32'b0010);

        // Reset in the middle of a word
        clear_q();
        pulse_start();
        send_word(32'd2, 1'b0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        #2 rst_n = 1'b0;
        #1 check("t6_rst_flags", {26'd0, bus.byte_ready, bus.wr_en, cpu_hold, busy, done, error}, 32'd0);
        check("t6_rst_data", bus.wr_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("t6_rst_wcnt", 32'(wq_data.size()), 32'd0);
        @(negedge clk);

        // Full-depth image, start pulsed while busy
        clear_q();
        for (int i = 0; i < 512; i++) exp_data.push_back({16'hC0DE, 16'(i)});
        pulse_start();
        send_word(32'd512, 1'b0);
        for (int i = 0; i < 10; i++) send_word(exp_data[i], 1'b0);
        pulse_start();
        check("t6_start_ignored", {16'd0, 15'd0, busy}, 32'd1);
        for (int i = 10; i < 512; i++) send_word(exp_data[i], 1'b0);
        wait_idle("t6_timeout");
        check("t6_ww", 32'(words_written), 32'd512);
        check("t6_last_addr", (wq_addr.size() > 0) ? wq_addr[wq_addr.size() - 1] : 32'hFFFF_FFFF, 32'h0000_07FC);
        check_writes("t6");
        check("t6_flags", {28'd0, cpu_hold, busy, done, error}, 32'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
